// File: rtl/tug_pkg.sv
// Shared constants and types for the tug-of-war game controller and the LED mux.
package tug_pkg;

  localparam int unsigned SCORE_W = 7;
  localparam int unsigned POS_W   = 3;
  localparam int unsigned LED_W   = 2;

  localparam logic [LED_W-1:0] LED_ALL   = 2'd0;
  localparam logic [LED_W-1:0] LED_NONE  = 2'd1;
  localparam logic [LED_W-1:0] LED_SCORE = 2'd3;

  localparam logic [POS_W-1:0] POS_CENTER = POS_W'(3);
  localparam logic [POS_W-1:0] POS_MAX    = POS_W'(6);

  typedef enum logic [1:0] {
    START = 2'd0,
    PLAY  = 2'd1,
    FLASH = 2'd2,
    DONE  = 2'd3
  } state_t;

  // One-hot bar with the lit LED at the given position (bit 6 = leftmost).
  function automatic logic [SCORE_W-1:0] pos_to_score(input logic [POS_W-1:0] pos);
    return SCORE_W'(1) << pos;
  endfunction

endpackage

// File: rtl/tug_ctrl_btn_edge.sv
// Button history register and rising-edge press pulse.
module btn_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press_c
);

  logic hist_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hist_q <= 1'b0;
    else        hist_q <= btn;
  end

  assign press_c = btn & ~hist_q;

endmodule

// File: rtl/tug_ctrl.sv
// Tug-of-war game FSM: lamp test, play, win flash, done; drives score bar and LED mode.
module tug_ctrl
  import tug_pkg::*;
#(
  parameter int unsigned INIT_TICKS  = 16,
  parameter int unsigned FLASH_TICKS = 8,
  parameter int unsigned FLASH_NUM   = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               btn_l,
  input  logic               btn_r,
  input  logic               restart,
  output logic [SCORE_W-1:0] score,
  output logic [LED_W-1:0]   leds_ctrl,
  output logic               win_l,
  output logic               win_r
);

  localparam int unsigned MAX_TICKS = (INIT_TICKS > FLASH_TICKS) ? INIT_TICKS : FLASH_TICKS;
  localparam int unsigned TICK_W    = $clog2(MAX_TICKS + 1);
  localparam int unsigned TOG_W     = $clog2(FLASH_NUM + 1);

  logic press_l_c, press_r_c;

  btn_edge u_edge_l (.clk(clk), .rst_n(rst_n), .btn(btn_l), .press_c(press_l_c));
  btn_edge u_edge_r (.clk(clk), .rst_n(rst_n), .btn(btn_r), .press_c(press_r_c));

  state_t             state_q, state_d;
  logic [TICK_W-1:0]  tick_q, tick_d;
  logic [TOG_W-1:0]   tog_q, tog_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic [SCORE_W-1:0] score_d;
  logic [LED_W-1:0]   leds_d;
  logic               win_l_d, win_r_d;

  // Next-state and next-output logic; restart overrides everything.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    tog_d   = tog_q;
    pos_d   = pos_q;
    score_d = score;
    leds_d  = leds_ctrl;
    win_l_d = win_l;
    win_r_d = win_r;
    if (restart) begin
      state_d = START;
      tick_d  = '0;
      tog_d   = '0;
      pos_d   = POS_CENTER;
      score_d = pos_to_score(POS_CENTER);
      leds_d  = LED_ALL;
      win_l_d = 1'b0;
      win_r_d = 1'b0;
    end else begin
      case (state_q)
        START: begin
          if (tick_q == TICK_W'(INIT_TICKS - 1)) begin
            state_d = PLAY;
            tick_d  = '0;
            leds_d  = LED_SCORE;
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
        PLAY: begin
          if (press_l_c && !press_r_c) begin
            if (pos_q == POS_MAX) begin
              state_d = FLASH;
              tick_d  = '0;
              tog_d   = '0;
              leds_d  = LED_SCORE;
              score_d = pos_to_score(POS_MAX);
              win_l_d = 1'b1;
            end else begin
              pos_d   = pos_q + POS_W'(1);
              score_d = pos_to_score(pos_q + POS_W'(1));
            end
          end else if (press_r_c && !press_l_c) begin
            if (pos_q == '0) begin
              state_d = FLASH;
              tick_d  = '0;
              tog_d   = '0;
              leds_d  = LED_SCORE;
              score_d = pos_to_score('0);
              win_r_d = 1'b1;
            end else begin
              pos_d   = pos_q - POS_W'(1);
              score_d = pos_to_score(pos_q - POS_W'(1));
            end
          end
        end
        FLASH: begin
          // FLASH_NUM is even, so the last toggle lands back on LED_SCORE.
          if (tick_q == TICK_W'(FLASH_TICKS - 1)) begin
            tick_d = '0;
            tog_d  = tog_q + TOG_W'(1);
            leds_d = (leds_ctrl == LED_SCORE) ? LED_NONE : LED_SCORE;
            if (tog_q == TOG_W'(FLASH_NUM - 1)) state_d = DONE;
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
        DONE: begin
          leds_d = LED_SCORE;
        end
        default: state_d = START;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= START;
      tick_q    <= '0;
      tog_q     <= '0;
      pos_q     <= POS_CENTER;
      score     <= pos_to_score(POS_CENTER);
      leds_ctrl <= LED_ALL;
      win_l     <= 1'b0;
      win_r     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      tog_q     <= tog_d;
      pos_q     <= pos_d;
      score     <= score_d;
      leds_ctrl <= leds_d;
      win_l     <= win_l_d;
      win_r     <= win_r_d;
    end
  end

endmodule

// File: tb/tb_tug_ctrl.sv
// Directed self-checking bench for tug_ctrl with short lamp test and flash timing.
module tb_tug_ctrl;

  logic       clk;
  logic       rst_n;
  logic       btn_l;
  logic       btn_r;
  logic       restart;
  logic [6:0] score;
  logic [1:0] leds_ctrl;
  logic       win_l;
  logic       win_r;

  int n_checks = 0;
  int n_errors = 0;

  logic [1:0] flash_seq [8] = '{2'd3, 2'd3, 2'd1, 2'd1, 2'd3, 2'd3, 2'd1, 2'd1};

  tug_ctrl #(.INIT_TICKS(4), .FLASH_TICKS(2), .FLASH_NUM(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_l    (btn_l),
    .btn_r    (btn_r),
    .restart  (restart),
    .score    (score),
    .leds_ctrl(leds_ctrl),
    .win_l    (win_l),
    .win_r    (win_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [1:0] leds, input logic [6:0] sc,
                            input logic wl, input logic wr);
    check({tag, "_leds"},  32'(leds_ctrl), 32'(leds));
    check({tag, "_score"}, 32'(score),     32'(sc));
    check({tag, "_win_l"}, 32'(win_l),     32'(wl));
    check({tag, "_win_r"}, 32'(win_r),     32'(wr));
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive buttons for exactly one sampling edge, then release.
  task automatic press(input logic l, input logic r);
    btn_l = l;
    btn_r = r;
    step();
    btn_l = 1'b0;
    btn_r = 1'b0;
  endtask

  // Expect four cycles of all-on, then score mode at center.
  task automatic lamp_test(input string tag);
    for (int i = 0; i < 4; i++) begin
      check({tag, "_lamp_leds"},  32'(leds_ctrl), 32'd0);
      check({tag, "_lamp_score"}, 32'(score),     32'h08);
      step();
    end
    check_outs({tag, "_play"}, 2'd3, 7'b0001000, 1'b0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; btn_l = 1'b0; btn_r = 1'b0; restart = 1'b0;
    step(2);
    check_outs("reset", 2'd0, 7'b0001000, 1'b0, 1'b0);
    rst_n = 1'b1;
    lamp_test("init");

    // Left march to a win, then the flash pattern
    press(1, 0); check("l1", 32'(score), 32'b0010000); step();
    press(1, 0); check("l2", 32'(score), 32'b0100000); step();
    press(1, 0); check("l3", 32'(score), 32'b1000000); step();
    press(1, 0);
    check_outs("lwin", 2'd3, 7'b1000000, 1'b1, 1'b0);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("lflash%0d", k), 32'(leds_ctrl), 32'(flash_seq[k]));
      step();
    end
    check_outs("ldone", 2'd3, 7'b1000000, 1'b1, 1'b0);
    step(3);
    check_outs("ldone_hold", 2'd3, 7'b1000000, 1'b1, 1'b0);
    press(0, 1); check_outs("ldone_press", 2'd3, 7'b1000000, 1'b1, 1'b0); step();

    // Restart held several cycles in DONE
    restart = 1'b1;
    step(6);
    restart = 1'b0;
    check_outs("rst_done", 2'd0, 7'b0001000, 1'b0, 1'b0);
    lamp_test("rst_done");

    // Simultaneous presses and a long hold
    press(1, 1); check("both", 32'(score), 32'b0001000); step();
    btn_l = 1'b1;
    step(); check("hold1", 32'(score), 32'b0010000);
    step(19); check("hold20", 32'(score), 32'b0010000);
    btn_l = 1'b0; step();

    // Right march from center to a right win
    press(0, 1); check("r0", 32'(score), 32'b0001000); step();
    press(0, 1); check("r1", 32'(score), 32'b0000100); step();
    press(0, 1); check("r2", 32'(score), 32'b0000010); step();
    press(0, 1); check("r3", 32'(score), 32'b0000001); step();
    press(0, 1);
    check_outs("rwin", 2'd3, 7'b0000001, 1'b0, 1'b1);
    press(1, 0);
    check_outs("rflash_press", 2'd3, 7'b0000001, 1'b0, 1'b1);
    step(6); check("rflash_e7", 32'(leds_ctrl), 32'd1);
    step();  check("rflash_e8", 32'(leds_ctrl), 32'd3);
    step(2);
    press(1, 0); check_outs("rdone_press", 2'd3, 7'b0000001, 1'b0, 1'b1); step();

    // Single-cycle restart in DONE
    restart = 1'b1; step(); restart = 1'b0;
    check_outs("rst_rdone", 2'd0, 7'b0001000, 1'b0, 1'b0);
    lamp_test("rst_rdone");

    // Mid-play restart coinciding with a press
    press(1, 0); step();
    press(1, 0); check("mid_pos", 32'(score), 32'b0100000); step();
    restart = 1'b1; btn_l = 1'b1;
    step();
    restart = 1'b0; btn_l = 1'b0;
    check_outs("rst_mid", 2'd0, 7'b0001000, 1'b0, 1'b0);
    lamp_test("rst_mid");

    // Asynchronous reset during FLASH, button held through release
    for (int i = 0; i < 4; i++) begin press(1, 0); step(); end
    press(1, 0);
    check("arst_win", 32'(win_l), 32'd1);
    step(3);
    #3 rst_n = 1'b0;
    #1 check_outs("arst", 2'd0, 7'b0001000, 1'b0, 1'b0);
    btn_l = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    lamp_test("arst");
    step(3); check("held_thru_rst", 32'(score), 32'b0001000);
    btn_l = 1'b0; step();
    press(1, 0); check("after_rst_press", 32'(score), 32'b0010000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/tug_ctrl.md
# tug_ctrl

Game controller for the tug-of-war board: turns two player buttons into the `score` position bar and the `leds_ctrl` display mode consumed by the LED multiplexer. It runs a power-up lamp test, then the play phase in which each press pulls the lit position toward that player, then a win flash sequence. It sits between the debounced button inputs and the LED mux, and is the sole producer of the mux's control and data inputs.

## Interface
- `INIT_TICKS`, 16: cycles of all-LEDs-on lamp test after reset/restart (≥1).
- `FLASH_TICKS`, 8: cycles per half-period of the win flash (≥1).
- `FLASH_NUM`, 6: display toggles in the win flash (even, ≥2).
- `clk` in 1: single clock; all logic on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `btn_l` in 1: left player button, debounced, synchronous to `clk`, level.
- `btn_r` in 1: right player button, same as `btn_l`.
- `restart` in 1: level; start a new game.
- `score` out 7: one-hot position bar, bit 6 = leftmost.
- `leds_ctrl` out 2: display mode: 0 = all on, 1 = all off, 3 = show `score`; 2 never driven.
- `win_l` out 1: left player has won; held until restart/reset.
- `win_r` out 1: right player has won; held until restart/reset.

## Operation
- All outputs registered. Reset values: state START, `leds_ctrl`=0, `score`=7'b0001000, `win_l`=`win_r`=0, counters 0, button history regs 0.
- Press = rising edge: input high now, previous sampled value low. History regs update every cycle in every state, so a button held across a state change never generates a press.
- States:
  - START: `leds_ctrl`=0, `score`=center. After INIT_TICKS cycles → PLAY, `leds_ctrl`=3.
  - PLAY: position index p (0..6, 3 = center, `score`=1<<p). Left press alone: p<6 → p+1; p=6 → left wins. Right press alone: p>0 → p−1; p=0 → right wins. Both presses in the same cycle: no move. No press: hold.
  - FLASH: entered on a win. `score` = winning edge bit (7'b1000000 left, 7'b0000001 right), `win_l`/`win_r` set. `leds_ctrl` starts at 3 and toggles 3↔1 every FLASH_TICKS cycles. After FLASH_NUM toggles → DONE.
  - DONE: `leds_ctrl`=3, `score` and win flag held. Presses ignored.
- Presses are ignored in START, FLASH and DONE.
- `restart`=1 in any state: next cycle state START, `leds_ctrl`=0, `score`=center, win flags cleared, counters cleared. Restart takes priority over a same-cycle press. While `restart` is held, the block stays in START with the counter held at 0.
- `rst_n` low mid-game returns all outputs to reset values immediately (asynchronously).

## Timing
- Press latency: `btn_l` rises before edge n and is sampled there; `score` shows the new position after edge n, i.e. 1 cycle.
- A winning press sets the win flag and `score` edge bit in the same cycle that FLASH is entered.
- START: `leds_ctrl`=0 for exactly INIT_TICKS cycles after reset deasserts, or after `restart` falls.
- FLASH: total duration FLASH_NUM×FLASH_TICKS cycles. It ends with `leds_ctrl`=3 because FLASH_NUM is even.
- Counter widths come from `$clog2` of the parameters and must not wrap before the terminal count.

## Structure
- Package `tug_pkg`:
  - LED mode constants LED_ALL=2'd0, LED_NONE=2'd1, LED_SCORE=2'd3.
  - State encoding START/PLAY/FLASH/DONE.
  - POS_CENTER=3 and POS_MAX=6.
  - The LED mux uses the same mode constants.
- One sub-module, `btn_edge`: registered history bit plus rising-edge pulse. Instantiated once per button.
- The top level holds the FSM, the tick counter (shared by START and FLASH), the toggle counter and the position register.

## Test plan
All scenarios use INIT_TICKS=4, FLASH_TICKS=2, FLASH_NUM=4.
1. Release reset → `leds_ctrl`=0 for 4 cycles, then 3. `score`=7'b0001000 throughout; win flags 0.
2. In PLAY, 3 single-cycle left presses → `score` 0010000, 0100000, 1000000, each 1 cycle after its press. A 4th left press → FLASH: `win_l`=1, `score`=1000000, `leds_ctrl` sequence 3,3,1,1,3,3,1,1 then 3 steady.
3. Left and right rise in the same cycle → `score` unchanged. Button held high for 20 cycles → exactly one move.
4. Right presses from center to a right win → `win_r`=1, `score`=7'b0000001. Presses during FLASH/DONE → no change.
5. Pulse `restart` in DONE, and again mid-PLAY at `score`=7'b0100000 → next cycle `leds_ctrl`=0, `score`=center, flags 0. Then the 4-cycle lamp test replays.
6. Assert `rst_n` low between clock edges during FLASH → outputs reach reset values without waiting for a clock edge. A button held high through reset release → no move on entering PLAY.
